apb_slave_regbank: RTL

//  APB slave register bank; the downstream stage of the testbench APB master (psel/penable/

---
 rtl/apb_slave_regbank.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/apb_slave_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : apb_slave_regbank
//  Description : APB slave register bank of DEPTH 32-bit words with a fixed
//                number of pready wait states per access. Out-of-range
//                accesses complete normally: writes are dropped and reads
//                return zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_regbank #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready
);

    localparam int unsigned c_AW   = $clog2(DEPTH);
    localparam logic [3:0]  c_WS   = 4'(WAIT_STATES);

    localparam logic [0:0]  c_IDLE   = 1'b0;
    localparam logic [0:0]  c_ACCESS = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_next_state;
    logic [3:0]  r_cnt;
    logic [29:0] r_addr;     // word address (paddr[31:2]) of the transfer in flight
    logic        r_write;
    logic [31:0] r_wdata;
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_prdata;

    logic        w_setup;
    logic        w_access;
    logic        w_done;
    logic        w_dec;
    logic        w_rd_load;
    logic [29:0] w_rd_addr;
    logic        w_rd_in_range;
    logic [31:0] w_rd_data;
    logic        w_wr_in_range;
    logic        w_wr_en;
    logic        w_pready;
    logic        w_unused_addr_bits;

    // Byte-lane bits carry no meaning for a word-wide bank.
    assign w_unused_addr_bits = &{1'b0, paddr[1:0]};

    // Bus phase decode relative to the current state.
    assign w_setup  = (r_state == c_IDLE)   && psel && !penable;
    assign w_access = (r_state == c_ACCESS) && psel && penable;
    assign w_done   = w_access && (r_cnt == 4'd0);
    assign w_dec    = w_access && (r_cnt != 4'd0);

    // Read data is captured on the edge after which pready goes high, so it
    // comes from the live address at setup (no waits) or the latched one.
    assign w_rd_load = (w_setup && !pwrite && (c_WS == 4'd0)) ||
                       (w_dec && (r_cnt == 4'd1) && !r_write);
    assign w_rd_addr     = (r_state == c_IDLE) ? paddr[31:2] : r_addr;
    assign w_rd_in_range = (w_rd_addr[29:c_AW] == '0);
    assign w_rd_data     = w_rd_in_range ? r_mem[w_rd_addr[c_AW-1:0]] : 32'h0;

    assign w_wr_in_range = (r_addr[29:c_AW] == '0);
    assign w_wr_en       = w_done && r_write && w_wr_in_range;

    // State register.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: setup opens an access, completion or abort closes it.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_setup) begin
                    w_next_state = c_ACCESS;
                end
            end
            c_ACCESS: begin
                if (!psel || w_done) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output logic: pready depends only on registered state.
    always_comb begin
        w_pready = 1'b0;
        if ((r_state == c_ACCESS) && (r_cnt == 4'd0)) begin
            w_pready = 1'b1;
        end
    end

    // Transfer latches and wait-state counter.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= 32'h0;
        end else if (w_setup) begin
            r_cnt   <= c_WS;
            r_addr  <= paddr[31:2];
            r_write <= pwrite;
            r_wdata <= pwdata;
        end else if (w_dec) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // Register storage; a write commits on its completion edge only.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (w_wr_en) begin
            r_mem[r_addr[c_AW-1:0]] <= r_wdata;
        end
    end

    // Read data register; holds its value until the next read load.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_prdata <= 32'h0;
        end else if (w_rd_load) begin
            r_prdata <= w_rd_data;
        end
    end

    assign prdata = r_prdata;
    assign pready = w_pready;

endmodule
`default_nettype wire
